// File: rtl/button_gesture_decoder.sv
// button_gesture_decoder
//
// Turns a clean (debounced) button level into gesture events for menu/UI
// logic: short press, long press and double click, plus a level flag while
// a long press is still held. All timing is measured in prescaled ticks.
//
// Handshake: none. The event outputs are one-clock pulses with no
// backpressure, so the consumer must sample them on every clock.
//
// Parameters
//   TICK_BITS  : prescaler width; one tick every 2**TICK_BITS clocks
//   LONG_TICKS : ticks a press must last to count as long (1..255)
//   GAP_TICKS  : max ticks from release to second press for a double click (1..255)
//
// Ports
//   i_clock   : system clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   i_button  : debounced button level, 1 = pressed, asynchronous to i_clock
//   o_short   : one-clock pulse, short press recognised
//   o_long    : one-clock pulse, long-press threshold reached
//   o_double  : one-clock pulse, double click recognised
//   o_held    : level, high while a long press is still held
//   o_busy    : level, high whenever the decoder is not idle
module button_gesture_decoder #(
  parameter int TICK_BITS  = 15,
  parameter int LONG_TICKS = 150,
  parameter int GAP_TICKS  = 90
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_button,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_held,
  output logic o_busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    LONG     = 3'd2,
    WAIT_GAP = 3'd3,
    SECOND   = 3'd4
  } state_t;

  // Threshold compares happen on the tick that would take the timer to N.
  localparam logic [7:0] LONG_LAST = 8'(LONG_TICKS - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);

  state_t               state;
  state_t               state_next;
  logic                 sync_meta;
  logic                 btn;
  logic [TICK_BITS-1:0] presc;
  logic                 tick;
  logic [7:0]           timer;
  logic                 short_next;
  logic                 long_next;
  logic                 double_next;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_meta <= 1'b0;
      btn       <= 1'b0;
    end else begin
      sync_meta <= i_button;
      btn       <= sync_meta;
    end
  end

  // Free-running prescaler; never cleared by state changes, which is why
  // threshold timing carries up to one tick period of uncertainty.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) presc <= '0;
    else            presc <= presc + TICK_BITS'(1);
  end

  assign tick = &presc;

  // Next-state and event decode. A button change is tested before the
  // threshold, so a coincident tick is discarded.
  always_comb begin
    state_next  = state;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    case (state)
      IDLE: begin
        if (btn) state_next = PRESSED;
      end
      PRESSED: begin
        if (!btn) begin
          state_next = WAIT_GAP;
        end else if (tick && timer == LONG_LAST) begin
          state_next = LONG;
          long_next  = 1'b1;
        end
      end
      LONG: begin
        if (!btn) state_next = IDLE;
      end
      WAIT_GAP: begin
        if (btn) begin
          state_next = SECOND;
        end else if (tick && timer == GAP_LAST) begin
          state_next = IDLE;
          short_next = 1'b1;
        end
      end
      SECOND: begin
        if (!btn) begin
          state_next  = IDLE;
          double_next = 1'b1;
        end else if (tick && timer == LONG_LAST) begin
          // The first click already completed as a short press.
          state_next = LONG;
          short_next = 1'b1;
          long_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  // Timer restarts on every state entry. It saturates rather than wraps so
  // a long hold in LONG or a long idle spell cannot alias a threshold.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      timer <= 8'd0;
    end else if (state_next != state) begin
      timer <= 8'd0;
    end else if (tick && timer != 8'hFF) begin
      timer <= timer + 8'd1;
    end
  end

  // Outputs are registered from the decoded next state so they appear on
  // the same edge that makes the decision.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_double <= 1'b0;
      o_held   <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      o_short  <= short_next;
      o_long   <= long_next;
      o_double <= double_next;
      o_held   <= (state_next == LONG);
      o_busy   <= (state_next != IDLE);
    end
  end

endmodule
